// File: rtl/pc_control.sv
// rtl/pc_control.sv - fetch-stage PC register with branch/jump redirect and memory-wait handling
module pc_control #(
  parameter logic [31:0] PC_RESET           = 32'h0000_0000,
  parameter int          REDIRECT_CNT_WIDTH = 16,
  localparam int         ISA_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pc_offset,
  input  logic [ISA_WIDTH-1:0]          pc_offset_value,
  input  logic                          pc_overload,
  input  logic [ISA_WIDTH-1:0]          pc_overload_value,
  input  logic [ISA_WIDTH-1:0]          id_pc,
  input  logic                          stall,
  input  logic                          imem_ready,
  output logic [ISA_WIDTH-1:0]          pc,
  output logic                          if_flush,
  output logic                          if_no_op,
  output logic [REDIRECT_CNT_WIDTH-1:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [REDIRECT_CNT_WIDTH-1:0] CNT_ONE = {{(REDIRECT_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ISA_WIDTH-1:0]          WORD    = 32'd4;

  state_t               state;
  state_t               state_next;
  logic [ISA_WIDTH-1:0] pending_target;
  logic [ISA_WIDTH-1:0] pending_next;
  logic [ISA_WIDTH-1:0] pc_next;
  logic [ISA_WIDTH-1:0] seq_pc;
  logic [ISA_WIDTH-1:0] offset_target;
  logic [ISA_WIDTH-1:0] target;
  logic                 req;
  logic                 cnt_inc;

  // Overload wins over offset; jump targets are forced to a word boundary.
  always_comb begin
    req           = pc_offset | pc_overload;
    seq_pc        = pc + WORD;
    offset_target = id_pc + WORD + (pc_offset_value << 2);
    target        = pc_overload ? (pc_overload_value & ~32'h3) : offset_target;
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    cnt_inc      = 1'b0;
    if_flush     = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (stall) begin
          pc_next = pc;
        end else if (req && imem_ready) begin
          pc_next  = target;
          if_flush = 1'b1;
          cnt_inc  = 1'b1;
        end else if (req) begin
          // The outstanding read for pc must finish before pc can move.
          pending_next = target;
          if_flush     = 1'b1;
          state_next   = PENDING;
        end else if (imem_ready) begin
          pc_next = seq_pc;
        end
      end
      PENDING: begin
        if (imem_ready) begin
          pc_next    = pending_target;
          cnt_inc    = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (rst) begin
      if_flush = 1'b0;
    end
  end

  assign if_no_op = rst | (state != RUN) | if_flush | ~imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= PC_RESET;
      pending_target <= PC_RESET;
      redirect_count <= '0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_next;
      if (cnt_inc) begin
        redirect_count <= redirect_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - directed scoreboard bench for pc_control
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic        pc_offset;
  logic [31:0] pc_offset_value;
  logic        pc_overload;
  logic [31:0] pc_overload_value;
  logic [31:0] id_pc;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        if_flush;
  logic        if_no_op;
  logic [15:0] redirect_count;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        no_op;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  pc_control dut (
    .clk               (clk),
    .rst               (rst),
    .pc_offset         (pc_offset),
    .pc_offset_value   (pc_offset_value),
    .pc_overload       (pc_overload),
    .pc_overload_value (pc_overload_value),
    .id_pc             (id_pc),
    .stall             (stall),
    .imem_ready        (imem_ready),
    .pc                (pc),
    .if_flush          (if_flush),
    .if_no_op          (if_no_op),
    .redirect_count    (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic ovl, input logic [31:0] ovl_v,
                       input logic off, input logic [31:0] off_v, input logic [31:0] idp,
                       input logic stl, input logic rdy);
    @(negedge clk);
    rst               = r;
    pc_overload       = ovl;
    pc_overload_value = ovl_v;
    pc_offset         = off;
    pc_offset_value   = off_v;
    id_pc             = idp;
    stall             = stl;
    imem_ready        = rdy;
  endtask

  // Drive one cycle, push the expected observation, then pop and compare before the next edge.
  task automatic step(input string tag, input logic r, input logic ovl, input logic [31:0] ovl_v,
                      input logic off, input logic [31:0] off_v, input logic [31:0] idp,
                      input logic stl, input logic rdy, input logic [31:0] e_pc,
                      input logic e_flush, input logic e_noop, input logic [15:0] e_cnt);
    exp_t e;
    drive(r, ovl, ovl_v, off, off_v, idp, stl, rdy);
    e.tag = tag; e.pc = e_pc; e.flush = e_flush; e.no_op = e_noop; e.cnt = e_cnt;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_assert++;
    assert (pc === e.pc) else begin
      n_fail++;
      $error("FAIL %s.pc observed %h expected %h", e.tag, pc, e.pc);
    end
    n_assert++;
    assert (if_flush === e.flush) else begin
      n_fail++;
      $error("FAIL %s.if_flush observed %b expected %b", e.tag, if_flush, e.flush);
    end
    n_assert++;
    assert (if_no_op === e.no_op) else begin
      n_fail++;
      $error("FAIL %s.if_no_op observed %b expected %b", e.tag, if_no_op, e.no_op);
    end
    n_assert++;
    assert (redirect_count === e.cnt) else begin
      n_fail++;
      $error("FAIL %s.redirect_count observed %h expected %h", e.tag, redirect_count, e.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; pc_overload = 1'b0; pc_overload_value = '0; pc_offset = 1'b0;
    pc_offset_value = '0; id_pc = '0; stall = 1'b0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);

    //    tag         rst ovl ovl_v         off off_v         id_pc     stl rdy  pc            fl no cnt
    step("reset",     1, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 1, 16'h0);
    step("boot",      0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 1, 16'h0);
    step("run0",      0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 0, 16'h0);
    step("run4",      0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0004, 0, 0, 16'h0);
    step("run8",      0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0008, 0, 0, 16'h0);
    step("run12",     0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_000C, 0, 0, 16'h0);
    step("branch",    0, 0, 32'h0,        1, 32'hFFFF_FFFE, 32'h100,  0, 1, 32'h0000_0010, 1, 1, 16'h0);
    step("br_tgt",    0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_00FC, 0, 0, 16'h1);
    step("jmp_br",    0, 1, 32'h0040_0013, 1, 32'h0000_0010, 32'h100,  0, 1, 32'h0000_0100, 1, 1, 16'h1);
    step("jmp_tgt",   0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0040_0010, 0, 1, 16'h2);
    step("jmp_run",   0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0040_0010, 0, 0, 16'h2);
    step("wait_req",  0, 1, 32'h0000_0200, 0, 32'h0,        32'h0,    0, 0, 32'h0040_0014, 1, 1, 16'h2);
    step("wait_req2", 0, 1, 32'h0000_0300, 0, 32'h0,        32'h0,    0, 0, 32'h0040_0014, 0, 1, 16'h2);
    step("wait3",     0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0040_0014, 0, 1, 16'h2);
    step("wait_rdy",  0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0040_0014, 0, 1, 16'h2);
    step("wait_tgt",  0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0200, 0, 0, 16'h3);
    step("stall_ovl", 0, 1, 32'h0000_0800, 0, 32'h0,        32'h0,    1, 1, 32'h0000_0204, 0, 0, 16'h3);
    step("stall_off", 0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0000_0204, 0, 1, 16'h3);
    step("pend_req",  0, 1, 32'h0000_0500, 0, 32'h0,        32'h0,    0, 0, 32'h0000_0204, 1, 1, 16'h3);
    step("pend_rst",  1, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0000_0204, 0, 1, 16'h3);
    step("rst_boot",  0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 1, 16'h0);
    step("rst_run",   0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 0, 16'h0);
    step("to_top",    0, 1, 32'hFFFF_FFFF, 0, 32'h0,        32'h0,    0, 1, 32'h0000_0004, 1, 1, 16'h0);
    step("at_top",    0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'hFFFF_FFFC, 0, 0, 16'h1);
    step("pc_wrap",   0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0000, 0, 0, 16'h1);

    for (int i = 0; i < 65534; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end

    step("cnt_max",   0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0040, 0, 0, 16'hFFFF);
    step("cnt_last",  0, 1, 32'h0000_0080, 0, 32'h0,        32'h0,    0, 1, 32'h0000_0044, 1, 1, 16'hFFFF);
    step("cnt_wrap",  0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 1, 32'h0000_0080, 0, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
